countgen_sampler: RTL and testbench

COUNTGEN_SAMPLER -- requirements
Module: countgen_sampler

---
 rtl/countgen_sampler_if.sv | 23 ++
 rtl/countgen_sampler.sv | 192 +++++++++++++++++++
 tb/tb_countgen_sampler.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/countgen_sampler_if.sv
// WISHBONE classic bus bundle used for both the config slave
// port and the countgen master port of countgen_sampler.
interface countgen_sampler_if #(
   parameter int AW = 4
) ();
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] adr;
   logic [31:0]   dat_w;
   logic [31:0]   dat_r;
   logic          ack;

   modport master (
      output cyc, stb, we, adr, dat_w,
      input  dat_r, ack
   );

   modport slave (
      input  cyc, stb, we, adr, dat_w,
      output dat_r, ack
   );
endinterface

// File: rtl/countgen_sampler.sv
// countgen_sampler: gated periodic scan of countgen channels,
// publishing per-channel count deltas over a WISHBONE slave.
module countgen_sampler #(
   parameter int          NUM_CH   = 8,
   parameter logic [31:0] GATE_RST = 32'd1000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   countgen_sampler_if.slave  s,
   countgen_sampler_if.master m,
   output logic               irq_o
);
   typedef enum logic [2:0] {
      IDLE, GATE, SCAN, BUS, CAPT
   } state_t;

   localparam logic [3:0] LAST   = 4'(NUM_CH);
   localparam logic [7:0] MASK_W = 8'((1 << NUM_CH) - 1);

   state_t      state_q, state_d;
   logic        ctrl_en, ctrl_irq;
   logic [31:0] gate_q;
   logic [7:0]  mask_q;
   logic        done_q, ovr_q, primed_q;
   logic [31:0] delta_q [8];
   logic [31:0] prev_q  [8];
   logic [31:0] timer_q;
   logic [3:0]  ptr_q;
   logic        m_cyc_q;
   logic [5:0]  m_adr_q;
   logic        s_ack_q;
   logic [31:0] s_dat_q;

   logic        req, wr;
   logic [3:0]  adr, dadr;
   logic        wr_ctrl, wr_gate, wr_mask, wr_stat;
   logic [31:0] reload, rdata;
   logic        run, expire, busy;
   logic [2:0]  idx;
   logic        load, scan_start, step, bus_go, capt, scan_end;

   assign req  = s.cyc & s.stb & ~s_ack_q;
   assign wr   = req & s.we;
   assign adr  = s.adr[3:0];
   assign dadr = adr - 4'd4;

   assign wr_ctrl = wr && (adr == 4'd0);
   assign wr_gate = wr && (adr == 4'd1);
   assign wr_mask = wr && (adr == 4'd2);
   assign wr_stat = wr && (adr == 4'd3);

   assign reload = (gate_q < 32'd2) ? 32'd1 : gate_q - 32'd1;
   assign run    = ctrl_en && (state_q != IDLE);
   assign expire = run && (timer_q == 32'd0);
   assign busy   = (state_q == SCAN) || (state_q == BUS) ||
                   (state_q == CAPT);
   assign idx    = ptr_q[2:0];

   assign s.ack   = s_ack_q;
   assign s.dat_r = s_dat_q;
   assign m.cyc   = m_cyc_q;
   assign m.stb   = m_cyc_q;
   assign m.we    = 1'b0;
   assign m.adr   = m_adr_q;
   assign m.dat_w = '0;
   assign irq_o   = done_q & ctrl_irq;

   always_comb begin
      rdata = '0;
      case (adr)
         4'd0: rdata = {30'd0, ctrl_irq, ctrl_en};
         4'd1: rdata = gate_q;
         4'd2: rdata = {24'd0, mask_q};
         4'd3: rdata = {29'd0, ovr_q, busy, done_q};
         default:
            if (adr >= 4'd4 && dadr < LAST)
               rdata = delta_q[dadr[2:0]];
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      scan_start = 1'b0;
      step       = 1'b0;
      bus_go     = 1'b0;
      capt       = 1'b0;
      scan_end   = 1'b0;
      unique case (state_q)
         IDLE:
            if (ctrl_en) begin
               state_d = GATE;
               load    = 1'b1;
            end
         GATE:
            if (!ctrl_en) begin
               state_d = IDLE;
            end else if (expire) begin
               state_d    = SCAN;
               scan_start = 1'b1;
            end
         SCAN:
            if (!ctrl_en) begin
               state_d = IDLE;
            end else if (ptr_q >= LAST) begin
               state_d  = GATE;
               scan_end = 1'b1;
            end else if (mask_q[idx]) begin
               state_d = BUS;
               bus_go  = 1'b1;
            end else begin
               step = 1'b1;
            end
         BUS:
            if (m.ack) state_d = CAPT;
         CAPT: begin
            capt    = 1'b1;
            state_d = ctrl_en ? SCAN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ctrl_en  <= 1'b0;
         ctrl_irq <= 1'b0;
         gate_q   <= GATE_RST;
         mask_q   <= MASK_W;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
         primed_q <= 1'b0;
         timer_q  <= '0;
         ptr_q    <= '0;
         m_cyc_q  <= 1'b0;
         m_adr_q  <= '0;
         s_ack_q  <= 1'b0;
         s_dat_q  <= '0;
         for (int i = 0; i < 8; i++) begin
            delta_q[i] <= '0;
            prev_q[i]  <= '0;
         end
      end else begin
         if (wr_ctrl) {ctrl_irq, ctrl_en} <= s.dat_w[1:0];
         if (wr_gate) gate_q <= s.dat_w;
         if (wr_mask) mask_q <= s.dat_w[7:0] & MASK_W;

         // hardware set beats a same-cycle software clear
         if (scan_end && primed_q)
            done_q <= 1'b1;
         else if (wr_stat && s.dat_w[0])
            done_q <= 1'b0;
         if (expire && state_q != GATE)
            ovr_q <= 1'b1;
         else if (wr_stat && s.dat_w[2])
            ovr_q <= 1'b0;

         if (load)          primed_q <= 1'b0;
         else if (scan_end) primed_q <= 1'b1;

         if (load)
            timer_q <= reload;
         else if (run)
            timer_q <= expire ? reload : timer_q - 32'd1;

         if (scan_start)     ptr_q <= '0;
         else if (step || capt) ptr_q <= ptr_q + 4'd1;

         if (bus_go) begin
            m_cyc_q <= 1'b1;
            m_adr_q <= {ptr_q + 4'd1, 2'b00};
         end else if (state_q == BUS && m.ack) begin
            m_cyc_q <= 1'b0;
         end

         // countgen holds its read data into the cycle after ack
         if (capt) begin
            prev_q[idx] <= m.dat_r;
            if (primed_q)
               delta_q[idx] <= m.dat_r - prev_q[idx];
         end

         s_ack_q <= req;
         s_dat_q <= req ? rdata : '0;
      end
   end
endmodule

// File: tb/tb_countgen_sampler.sv
// Directed bench for countgen_sampler with a behavioural
// countgen responder returning base + step * reads.
module tb_countgen_sampler;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic irq_o;

   countgen_sampler_if #(.AW(4)) s_bus ();
   countgen_sampler_if #(.AW(6)) m_bus ();

   countgen_sampler #(.NUM_CH(8), .GATE_RST(32'd1000)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .s     (s_bus),
      .m     (m_bus),
      .irq_o (irq_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] cg_base  [8];
   logic [31:0] cg_step  [8];
   int          cg_nbase [8];
   int          cg_nrd   [8];
   int          cg_delay;
   int          wcnt;
   logic [5:0]  adr_log [$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk_i) begin
      int ch;
      ch = int'(m_bus.adr >> 2) - 1;
      if (!rst_i) begin
         m_bus.ack <= 1'b0;
         wcnt      <= 0;
      end else if (m_bus.cyc && m_bus.stb && !m_bus.ack) begin
         if (wcnt >= cg_delay && ch >= 0 && ch < 8) begin
            m_bus.ack   <= 1'b1;
            m_bus.dat_r <= cg_base[ch] + cg_step[ch] *
                           32'(cg_nrd[ch] - cg_nbase[ch]);
            cg_nrd[ch]  <= cg_nrd[ch] + 1;
            adr_log.push_back(m_bus.adr);
            wcnt        <= 0;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         m_bus.ack <= 1'b0;
         if (!(m_bus.cyc && m_bus.stb)) wcnt <= 0;
      end
   end

   task automatic wb_wr(input logic [3:0] a, input logic [31:0] d);
      int n = 0;
      @(negedge clk_i);
      s_bus.cyc = 1; s_bus.stb = 1; s_bus.we = 1;
      s_bus.adr = a; s_bus.dat_w = d;
      do begin @(posedge clk_i); #1; n++; end
      while (!s_bus.ack && n < 20);
      if (!s_bus.ack) check("wr_ack_timeout", 32'(s_bus.ack), 1);
      @(negedge clk_i);
      s_bus.cyc = 0; s_bus.stb = 0; s_bus.we = 0;
   endtask

   task automatic wb_rd(input logic [3:0] a, output logic [31:0] d);
      int n = 0;
      @(negedge clk_i);
      s_bus.cyc = 1; s_bus.stb = 1; s_bus.we = 0; s_bus.adr = a;
      do begin @(posedge clk_i); #1; n++; end
      while (!s_bus.ack && n < 20);
      if (!s_bus.ack) check("rd_ack_timeout", 32'(s_bus.ack), 1);
      d = s_bus.dat_r;
      @(negedge clk_i);
      s_bus.cyc = 0; s_bus.stb = 0;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a,
                         input logic [31:0] exp);
      logic [31:0] d;
      wb_rd(a, d);
      check(tag, d, exp);
   endtask

   task automatic wait_rd(input int n);
      int k = 0;
      while (adr_log.size() < n && k < 2000) begin
         @(posedge clk_i); k++;
      end
      #1;
      if (adr_log.size() < n)
         check("wait_rd_timeout", 32'(adr_log.size()), 32'(n));
   endtask

   task automatic wait_cyc();
      int k = 0;
      while (!m_bus.cyc && k < 500) begin
         @(posedge clk_i); #1; k++;
      end
      if (!m_bus.cyc) check("wait_cyc_timeout", 32'(m_bus.cyc), 1);
   endtask

   task automatic cg_set(input int ch, input logic [31:0] b,
                         input logic [31:0] st);
      cg_base[ch]  = b;
      cg_step[ch]  = st;
      cg_nbase[ch] = cg_nrd[ch];
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      int r0;
      for (int i = 0; i < 8; i++) begin
         cg_base[i] = 0; cg_step[i] = 0;
         cg_nbase[i] = 0; cg_nrd[i] = 0;
      end
      cg_delay = 0;
      s_bus.cyc = 0; s_bus.stb = 0; s_bus.we = 0;
      s_bus.adr = 0; s_bus.dat_w = 0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;

      check("rst_m_cyc", 32'(m_bus.cyc), 0);
      check("rst_m_adr", 32'(m_bus.adr), 0);
      check("rst_irq", 32'(irq_o), 0);
      rd_chk("rst_ctrl", 4'd0, 32'd0);
      rd_chk("rst_gate", 4'd1, 32'd1000);
      rd_chk("rst_mask", 4'd2, 32'hFF);
      rd_chk("rst_status", 4'd3, 32'd0);
      rd_chk("rst_delta0", 4'd4, 32'd0);
      rd_chk("unmapped_rd", 4'd13, 32'd0);

      // basic delta: 100 then 150
      cg_set(0, 32'd100, 32'd50);
      wb_wr(4'd1, 32'd10);
      wb_wr(4'd2, 32'h01);
      wb_wr(4'd0, 32'h1);
      wait_rd(1);
      repeat (14) @(posedge clk_i);
      wb_rd(4'd3, d);
      check("scan1_no_done", d & 32'h1, 0);
      rd_chk("scan1_delta0", 4'd4, 32'd0);
      wait_rd(2);
      repeat (14) @(posedge clk_i);
      rd_chk("scan2_delta0", 4'd4, 32'd50);
      wb_rd(4'd3, d);
      check("scan2_done", d & 32'h1, 1);
      check("irq_masked", 32'(irq_o), 0);
      wb_wr(4'd0, 32'h3);
      check("irq_enabled", 32'(irq_o), 1);
      wb_wr(4'd0, 32'h2);
      repeat (40) @(posedge clk_i);
      rd_chk("ovr_done_status", 4'd3, 32'h5);
      wb_wr(4'd3, 32'h5);
      rd_chk("w1c_status", 4'd3, 32'h0);
      #1;
      check("irq_cleared", 32'(irq_o), 0);

      // empty mask still completes scans
      r0 = adr_log.size();
      wb_wr(4'd2, 32'h00);
      wb_wr(4'd0, 32'h1);
      repeat (50) @(posedge clk_i);
      wb_wr(4'd0, 32'h0);
      repeat (5) @(posedge clk_i);
      rd_chk("mask0_status", 4'd3, 32'h1);
      check("mask0_no_bus", 32'(adr_log.size()), 32'(r0));
      wb_wr(4'd3, 32'h7);

      // scan order and 32-bit wrap
      cg_set(0, 32'hFFFF_FFF0, 32'h20);
      cg_set(2, 32'd1000, 32'd7);
      r0 = adr_log.size();
      wb_wr(4'd1, 32'd40);
      wb_wr(4'd2, 32'h05);
      wb_wr(4'd0, 32'h1);
      wait_rd(r0 + 4);
      repeat (12) @(posedge clk_i);
      check("order0", 32'(adr_log[r0]), 32'd4);
      check("order1", 32'(adr_log[r0+1]), 32'd12);
      check("order2", 32'(adr_log[r0+2]), 32'd4);
      check("order3", 32'(adr_log[r0+3]), 32'd12);
      rd_chk("wrap_delta0", 4'd4, 32'h20);
      rd_chk("delta1_untouched", 4'd5, 32'd0);
      rd_chk("delta2", 4'd6, 32'd7);
      wb_wr(4'd0, 32'h0);
      repeat (40) @(posedge clk_i);
      wb_wr(4'd3, 32'h7);

      // slow countgen against a short gate
      cg_set(0, 32'd500, 32'd3);
      cg_delay = 5;
      r0 = adr_log.size();
      wb_wr(4'd1, 32'd2);
      wb_wr(4'd2, 32'h01);
      wb_wr(4'd0, 32'h1);
      wait_rd(r0 + 2);
      repeat (20) @(posedge clk_i);
      wb_wr(4'd0, 32'h0);
      repeat (20) @(posedge clk_i);
      rd_chk("overrun_status", 4'd3, 32'h5);
      rd_chk("overrun_delta0", 4'd4, 32'd3);
      wb_wr(4'd3, 32'h7);

      // disable and mask change while waiting on ack
      cg_set(0, 32'd10, 32'd1);
      cg_delay = 20;
      r0 = adr_log.size();
      wb_wr(4'd1, 32'd40);
      wb_wr(4'd0, 32'h1);
      wait_cyc();
      rd_chk("busy_in_bus", 4'd3, 32'h2);
      wb_wr(4'd2, 32'h00);
      wb_wr(4'd0, 32'h0);
      check("cyc_held", 32'(m_bus.cyc), 1);
      check("adr_held", 32'(m_bus.adr), 32'd4);
      wait_rd(r0 + 1);
      repeat (5) @(posedge clk_i);
      #1;
      check("cyc_dropped", 32'(m_bus.cyc), 0);
      rd_chk("disable_status", 4'd3, 32'h0);
      rd_chk("disable_delta0", 4'd4, 32'd3);

      // asynchronous reset during a bus cycle
      wb_wr(4'd2, 32'h01);
      wb_wr(4'd0, 32'h1);
      wait_cyc();
      rst_i = 1'b0;
      #1;
      check("arst_cyc", 32'(m_bus.cyc), 0);
      check("arst_stb", 32'(m_bus.stb), 0);
      check("arst_adr", 32'(m_bus.adr), 0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;
      rd_chk("arst_ctrl", 4'd0, 32'd0);
      rd_chk("arst_gate", 4'd1, 32'd1000);
      rd_chk("arst_mask", 4'd2, 32'hFF);
      rd_chk("arst_delta0", 4'd4, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
